// File: rtl/mem_responder_if.sv
// Request/response bus between a multicycle datapath and mem_responder.
// The datapath drives the master side; the responder is the slave.
interface mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ready, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ready, busy
   );
endinterface

// File: rtl/mem_responder.sv
// Word memory with programmable wait states behind a req/ready handshake.
// Define MEM_WAIT_STATE_EN to honour WAIT; otherwise every access waits 0.
module mem_responder #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_BITS = 4'(WAIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic            accept;
   logic            go_resp;
   logic            wait_done;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic [31:0]     rdata_q;
   logic [31:0]     mem [DEPTH];

   logic            unused_addr;
   assign unused_addr = ^bus.addr[31:AW];

`ifdef MEM_WAIT_STATE_EN
   logic [3:0] cnt_q;

   assign wait_done = (cnt_q == 4'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= 4'd0;
      end else if (accept) begin
         cnt_q <= WAIT_BITS;
      end else if (state_q == S_WAIT) begin
         if (!bus.req || wait_done) begin
            cnt_q <= 4'd0;
         end else begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end
`else
   logic unused_wait;
   assign unused_wait = ^WAIT_BITS;
   assign wait_done   = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      go_resp = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               accept  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Dropping req mid-wait abandons the access.
            if (!bus.req) begin
               state_d = S_IDLE;
            end else if (wait_done) begin
               go_resp = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
      end else if (accept) begin
         we_q    <= bus.we;
         addr_q  <= bus.addr[AW-1:0];
         wdata_q <= bus.wdata;
      end
   end

   // Storage is never reset; go_resp is low while reset holds IDLE.
   always_ff @(posedge clk) begin
      if (go_resp && we_q) begin
         mem[addr_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= 32'h0;
      end else if (go_resp) begin
         rdata_q <= we_q ? wdata_q : mem[addr_q];
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = (state_q == S_RESP);
   assign bus.busy  = (state_q == S_WAIT) || (state_q == S_RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=64, WAIT=2).
// Expected latency follows MEM_WAIT_STATE_EN: WAIT+2 edges, or 2 without.
module tb_mem_responder;

`ifdef MEM_WAIT_STATE_EN
   localparam int EW = 2;
`else
   localparam int EW = 0;
`endif

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   np;
   int   seen;
   int   p [3];

   mem_responder_if bus ();

   mem_responder #(
      .DEPTH (64),
      .WAIT  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction; inputs are scrambled after capture.
   task automatic txn(input string tag,
                      input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [31:0] exp);
      int n;
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            bus.we    = ~w;
            bus.addr  = ~a;
            bus.wdata = ~d;
         end
      end while (bus.ready !== 1'b1 && n < 40);
      chk({tag, "_latency"}, 32'(n), 32'(EW + 2));
      chk({tag, "_rdata"}, bus.rdata, exp);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 32'(bus.ready), 32'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      p[0]      = 0;
      p[1]      = 0;
      p[2]      = 0;
      reset     = 1'b0;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;

      #3;
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      txn("st5", 1'b1, 32'd5, 32'hDEADBEEF, 32'hDEADBEEF);
      txn("ld5", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF);

      txn("st3", 1'b1, 32'd3, 32'h11111111, 32'h11111111);
      txn("ld67", 1'b0, 32'd67, 32'h0, 32'h11111111);

      txn("st9", 1'b1, 32'd9, 32'hCAFEF00D, 32'hCAFEF00D);
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 32'd9;
      bus.wdata = 32'hAAAA5555;
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.ready === 1'b1) seen++;
      end
      chk("abort_noready", 32'(seen), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_hold", bus.rdata, 32'hCAFEF00D);
      txn("ld9", 1'b0, 32'd9, 32'h0, 32'hCAFEF00D);

      txn("st12", 1'b1, 32'd12, 32'h01020304, 32'h01020304);
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 32'd12;
      bus.wdata = 32'h99999999;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_ready", 32'(bus.ready), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_rdata", bus.rdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      reset   = 1'b1;
      txn("ld12", 1'b0, 32'd12, 32'h0, 32'h01020304);

      // req held high: pulses every EW+3 edges (EW+2 idle cycles between).
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 32'd5;
      np = 0;
      for (int i = 1; i <= 3 * EW + 9; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready === 1'b1) begin
            if (np < 3) begin
               p[np] = i;
               chk("b2b_rdata", bus.rdata, 32'hDEADBEEF);
            end
            np++;
         end
      end
      @(negedge clk);
      bus.req = 1'b0;
      chk("b2b_count", 32'(np), 32'd3);
      chk("b2b_first", 32'(p[0]), 32'(EW + 2));
      chk("b2b_gap1", 32'(p[1] - p[0]), 32'(EW + 3));
      chk("b2b_gap2", 32'(p[2] - p[1]), 32'(EW + 3));
      repeat (3) @(posedge clk);
      #1;
      chk("end_busy", 32'(bus.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
